// File: rtl/recon_error_monitor_if.sv
// Signal bundle between the reconstruction error monitor and its environment.
// Carries the two sample streams, the run request and the run results.
interface recon_error_monitor_if #(
   parameter int W = 16
);
   // x_in/xs_in carry a new sample on every rising clk edge; there is no valid or
   // ready, and the stream cannot be stalled. start is a single-cycle request,
   // sampled on the rising edge and acted on only in IDLE or DONE.
   logic signed [W-1:0] x_in;
   logic signed [W-1:0] xs_in;
   logic                start;
   logic                busy;
   logic                done;
   logic                pass;
   logic [W-1:0]        max_err;
   logic [31:0]         err_sum;
   logic [9:0]          mismatch_cnt;
   logic [9:0]          first_idx;
   // Debug view of the FSM: 0 IDLE, 1 WARMUP, 2 COMPARE, 3 DONE.
   logic [1:0]          fsm_state;

   modport master (
      output x_in, xs_in, start,
      input  busy, done, pass, max_err, err_sum, mismatch_cnt, first_idx, fsm_state
   );

   modport slave (
      input  x_in, xs_in, start,
      output busy, done, pass, max_err, err_sum, mismatch_cnt, first_idx, fsm_state
   );
endinterface

// File: rtl/recon_error_monitor.sv
// Compares the reconstructed stream against the delayed original over one frame
// and accumulates error statistics plus a pass flag.
module recon_error_monitor #(
   parameter int W     = 16,
   parameter int DELAY = 6,
   parameter int FRAME = 1000,
   parameter int TOL   = 4
) (
   input logic                  clk,
   input logic                  reset,
   recon_error_monitor_if.slave mon
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WARMUP  = 2'd1,
      COMPARE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [W-1:0] TOL_W      = W'(TOL);
   localparam logic [5:0]   WARM_LAST  = 6'(DELAY - 1);
   localparam logic [9:0]   FRAME_LAST = 10'(FRAME - 1);

   state_t              state;
   state_t              state_next;
   logic                clear_stats;
   logic                do_cmp;
   logic [W-1:0]        dly [DELAY];
   logic [W-1:0]        x_d;
   logic signed [W:0]   err;
   logic [W-1:0]        mag;
   logic                mismatch;
   logic [32:0]         sum_ext;
   logic [5:0]          warm_cnt;
   logic [9:0]          idx;
   logic [W-1:0]        max_err;
   logic [31:0]         err_sum;
   logic [9:0]          mismatch_cnt;
   logic [9:0]          first_idx;

   // The delay line shifts in every state so x_d is always aligned with xs_in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DELAY; i++) dly[i] <= '0;
      end else begin
         dly[0] <= mon.x_in;
         for (int i = 1; i < DELAY; i++) dly[i] <= dly[i-1];
      end
   end

   assign x_d      = dly[DELAY-1];
   assign err      = $signed({mon.xs_in[W-1], mon.xs_in}) - $signed({x_d[W-1], x_d});
   assign mag      = err[W] ? W'(-err) : W'(err);
   assign mismatch = (mag > TOL_W);
   assign sum_ext  = {1'b0, err_sum} + 33'(mag);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next  = state;
      clear_stats = 1'b0;
      do_cmp      = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (mon.start) begin
               clear_stats = 1'b1;
               state_next  = WARMUP;
            end
         end
         WARMUP: begin
            if (warm_cnt == WARM_LAST) state_next = COMPARE;
         end
         COMPARE: begin
            do_cmp = 1'b1;
            if (idx == FRAME_LAST) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         warm_cnt <= '0;
         idx      <= '0;
      end else begin
         if (clear_stats)           warm_cnt <= '0;
         else if (state == WARMUP)  warm_cnt <= warm_cnt + 6'd1;
         if (clear_stats)           idx <= '0;
         else if (do_cmp)           idx <= idx + 10'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         max_err      <= '0;
         err_sum      <= '0;
         mismatch_cnt <= '0;
         first_idx    <= 10'h3FF;
      end else if (clear_stats) begin
         max_err      <= '0;
         err_sum      <= '0;
         mismatch_cnt <= '0;
         first_idx    <= 10'h3FF;
      end else if (do_cmp) begin
         if (mag > max_err) max_err <= mag;
         err_sum <= sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
         if (mismatch && mismatch_cnt != 10'h3FF) mismatch_cnt <= mismatch_cnt + 10'd1;
         if (mismatch && mismatch_cnt == 10'd0)   first_idx    <= idx;
      end
   end

   assign mon.busy         = (state == WARMUP) || (state == COMPARE);
   assign mon.done         = (state == DONE);
   assign mon.pass         = (state == DONE) && (mismatch_cnt == 10'd0);
   assign mon.max_err      = max_err;
   assign mon.err_sum      = err_sum;
   assign mon.mismatch_cnt = mismatch_cnt;
   assign mon.first_idx    = first_idx;
   assign mon.fsm_state    = state;
endmodule

// File: tb/tb_recon_error_monitor.sv
// Bench for recon_error_monitor: directed frame table, control corner cases and
// random frames checked against a time-indexed reference model.
module tb_recon_error_monitor;
   localparam int W     = 16;
   localparam int DELAY = 6;
   localparam int FRAME = 1000;
   localparam int TOL   = 4;
   localparam int MAXC  = 32768;

   typedef struct {
      int     lo0, hi0, v0;
      int     lo1, hi1, v1;
      bit     ext;
      int     e_mcnt;
      int     e_first;
      int     e_max;
      longint e_sum;
      bit     e_pass;
   } vec_t;

   logic clk;
   logic reset;
   recon_error_monitor_if #(.W(W)) ifc ();

   recon_error_monitor #(.W(W), .DELAY(DELAY), .FRAME(FRAME), .TOL(TOL)) dut (
      .clk   (clk),
      .reset (reset),
      .mon   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int                  n_vec  = 0;
   int                  n_miss = 0;
   int                  cyc    = 0;
   int                  run_t  = -1000000;
   bit                  rnd_mode = 1'b0;
   bit                  ext_mode = 1'b0;
   int                  inj [FRAME];
   logic signed [W-1:0] x_hist  [MAXC];
   logic signed [W-1:0] xs_hist [MAXC];
   logic [31:0]         exp_q [$];
   vec_t                tbl [4];

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive the sample pair for the next edge, record it by edge number, then step.
   task automatic drive_cycle(input bit st, input bit new_run);
      int e, k0, k;
      logic signed [W-1:0] xv, xsv;
      e = cyc + 1;
      if (new_run) run_t = e;
      k0 = e - run_t - 1;
      k  = e - run_t - DELAY - 1;
      if (k0 >= 0 && k0 < FRAME) begin
         if (ext_mode && k0 == 0) xv = 16'sh8000;
         else if (rnd_mode)       xv = W'($urandom);
         else                     xv = W'(k0);
      end else begin
         xv = W'($urandom);
      end
      if (e < MAXC) x_hist[e] = xv;
      if (k >= 0 && k < FRAME) begin
         if (ext_mode && k == 0) xsv = 16'sh7FFF;
         else                    xsv = W'(int'(x_hist[e-DELAY]) + inj[k]);
      end else begin
         xsv = W'($urandom);
      end
      if (e < MAXC) xs_hist[e] = xsv;
      ifc.x_in  = xv;
      ifc.xs_in = xsv;
      ifc.start = st;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic set_inj(input int lo0, hi0, v0, lo1, hi1, v1);
      for (int k = 0; k < FRAME; k++) begin
         inj[k] = 0;
         if (k >= lo0 && k <= hi0) inj[k] = v0;
         if (k >= lo1 && k <= hi1) inj[k] = v1;
      end
   endtask

   // Reference: compared sample k pairs xs from edge t+DELAY+1+k with x from edge t+1+k.
   task automatic model_run(input int t);
      int     mx, mc, fi, e, a;
      longint s;
      mx = 0; mc = 0; fi = 1023; s = 0;
      for (int k = 0; k < FRAME; k++) begin
         e = int'(xs_hist[t+DELAY+1+k]) - int'(x_hist[t+1+k]);
         a = (e < 0) ? -e : e;
         if (a > mx) mx = a;
         s = s + a;
         if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
         if (a > TOL) begin
            if (mc == 0) fi = k;
            if (mc < 1023) mc++;
         end
      end
      exp_q.push_back(32'(mx));
      exp_q.push_back(32'(s));
      exp_q.push_back(32'(mc));
      exp_q.push_back(32'(fi));
      exp_q.push_back(32'(mc == 0));
   endtask

   task automatic check_from_q(input string tag);
      check({tag, "_max_err"},  ifc.max_err,      exp_q.pop_front());
      check({tag, "_err_sum"},  ifc.err_sum,      exp_q.pop_front());
      check({tag, "_mcnt"},     ifc.mismatch_cnt, exp_q.pop_front());
      check({tag, "_first"},    ifc.first_idx,    exp_q.pop_front());
      check({tag, "_pass"},     ifc.pass,         exp_q.pop_front());
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_max_err"}, ifc.max_err,      0);
      check({tag, "_err_sum"}, ifc.err_sum,      0);
      check({tag, "_mcnt"},    ifc.mismatch_cnt, 0);
      check({tag, "_first"},   ifc.first_idx,    10'h3FF);
      check({tag, "_pass"},    ifc.pass,         0);
   endtask

   // One full run; optional start pulse at edge t+pulse_j.
   task automatic do_run(input int pulse_j);
      drive_cycle(1'b1, 1'b1);
      check("start_busy", ifc.busy, 1);
      check("start_done", ifc.done, 0);
      for (int j = 1; j <= DELAY + FRAME; j++) begin
         drive_cycle(j == pulse_j, 1'b0);
         if (j == DELAY + FRAME - 1) check("pre_done", ifc.done, 0);
      end
      check("end_done", ifc.done, 1);
      check("end_busy", ifc.busy, 0);
   endtask

   initial begin
      tbl[0] = '{lo0:-1, hi0:-1, v0:0, lo1:-1, hi1:-1, v1:0,  ext:0,
                 e_mcnt:0, e_first:1023, e_max:0,     e_sum:0,     e_pass:1};
      tbl[1] = '{lo0:10, hi0:10, v0:5, lo1:500, hi1:500, v1:-3, ext:0,
                 e_mcnt:1, e_first:10,   e_max:5,     e_sum:8,     e_pass:0};
      tbl[2] = '{lo0:0,  hi0:9,  v0:4, lo1:10, hi1:19, v1:-4, ext:0,
                 e_mcnt:0, e_first:1023, e_max:4,     e_sum:80,    e_pass:1};
      tbl[3] = '{lo0:-1, hi0:-1, v0:0, lo1:-1, hi1:-1, v1:0,  ext:1,
                 e_mcnt:1, e_first:0,    e_max:65535, e_sum:65535, e_pass:0};

      ifc.x_in = '0; ifc.xs_in = '0; ifc.start = 1'b0;
      set_inj(-1, -1, 0, -1, -1, 0);
      reset = 1'b1;
      repeat (3) drive_cycle(1'b0, 1'b0);
      check("rst_busy", ifc.busy, 0);
      check("rst_done", ifc.done, 0);
      check("rst_state", ifc.fsm_state, 0);
      check_cleared("rst");
      reset = 1'b0;
      repeat (2) drive_cycle(1'b0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         set_inj(tbl[i].lo0, tbl[i].hi0, tbl[i].v0, tbl[i].lo1, tbl[i].hi1, tbl[i].v1);
         ext_mode = tbl[i].ext;
         do_run(-1);
         check($sformatf("v%0d_mcnt", i),  ifc.mismatch_cnt, tbl[i].e_mcnt);
         check($sformatf("v%0d_first", i), ifc.first_idx,    tbl[i].e_first);
         check($sformatf("v%0d_max", i),   ifc.max_err,      tbl[i].e_max);
         check($sformatf("v%0d_sum", i),   ifc.err_sum,      tbl[i].e_sum);
         check($sformatf("v%0d_pass", i),  ifc.pass,         tbl[i].e_pass);
      end
      ext_mode = 1'b0;

      // Restart from DONE after an injected-error run.
      set_inj(10, 10, 5, 500, 500, -3);
      do_run(-1);
      check("inj2_mcnt", ifc.mismatch_cnt, 1);
      set_inj(-1, -1, 0, -1, -1, 0);
      drive_cycle(1'b1, 1'b1);
      check("restart_done", ifc.done, 0);
      check_cleared("restart");
      for (int j = 1; j <= DELAY + FRAME; j++) drive_cycle(1'b0, 1'b0);
      check("restart_end_done", ifc.done, 1);
      check("restart_end_pass", ifc.pass, 1);
      check("restart_end_mcnt", ifc.mismatch_cnt, 0);

      // start pulses in WARMUP and COMPARE are ignored; done keeps its cycle.
      set_inj(200, 200, 7, -1, -1, 0);
      drive_cycle(1'b1, 1'b1);
      for (int j = 1; j <= DELAY + FRAME; j++) begin
         drive_cycle((j == 2) || (j == DELAY + 101), 1'b0);
         if (j == DELAY + FRAME - 1) check("pulse_pre_done", ifc.done, 0);
      end
      check("pulse_done", ifc.done, 1);
      check("pulse_mcnt", ifc.mismatch_cnt, 1);
      check("pulse_first", ifc.first_idx, 200);

      // Asynchronous reset after compare index 299 has been processed.
      set_inj(50, 50, 9, -1, -1, 0);
      drive_cycle(1'b1, 1'b1);
      for (int j = 1; j <= DELAY + 300; j++) drive_cycle(1'b0, 1'b0);
      check("mid_mcnt", ifc.mismatch_cnt, 1);
      check("mid_first", ifc.first_idx, 50);
      check("mid_busy", ifc.busy, 1);
      reset = 1'b1;
      #1;
      check("arst_busy", ifc.busy, 0);
      check("arst_done", ifc.done, 0);
      check("arst_state", ifc.fsm_state, 0);
      check_cleared("arst");
      drive_cycle(1'b0, 1'b0);
      reset = 1'b0;
      repeat (3) drive_cycle(1'b0, 1'b0);
      check("post_rst_busy", ifc.busy, 0);
      check("post_rst_done", ifc.done, 0);

      // Random frames with sparse small and large errors.
      rnd_mode = 1'b1;
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < FRAME; k++) begin
            int p;
            p = int'($urandom_range(0, 99));
            if (p < 5)      inj[k] = int'($urandom_range(0, 2*TOL + 8)) - (TOL + 4);
            else if (p < 7) inj[k] = int'($urandom_range(0, 60000)) - 30000;
            else            inj[k] = 0;
         end
         do_run(-1);
         model_run(run_t);
         check_from_q($sformatf("rnd%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
